// File: rtl/sprite_pkg.sv
// Shared sprite constants and types.
// Used by the sprite fetch unit, the sprite ROM wrappers and the colour mapper.
package sprite_pkg;

  localparam int unsigned SPR_W  = 60;  // sprite width in pixels
  localparam int unsigned SPR_H  = 60;  // sprite height in pixels
  localparam int unsigned ADDR_W = 12;  // sprite ROM address width
  localparam int unsigned IDX_W  = 5;   // palette index width
  localparam int unsigned XY_W   = 10;  // raster / position coordinate width

  typedef logic [IDX_W-1:0]  pal_idx_t;
  typedef logic [ADDR_W-1:0] spr_addr_t;
  typedef logic [XY_W-1:0]   coord_t;

  // Palette index treated as see-through.
  localparam pal_idx_t TRANSPARENT = '0;

endpackage

// File: rtl/sprite_hit_calc.sv
// Combinational sprite hit test and ROM address generation.
// Ports:
//   draw_x_i, draw_y_i : current raster position
//   sx_i, sy_i         : latched sprite top-left corner
//   flip_i             : latched horizontal mirror flag
//   hit_o              : raster position lies inside the sprite box
//   addr_o             : ROM address of the sprite texel (meaningful only when hit_o)
module sprite_hit_calc
  import sprite_pkg::*;
(
  input  coord_t    draw_x_i,
  input  coord_t    draw_y_i,
  input  coord_t    sx_i,
  input  coord_t    sy_i,
  input  logic      flip_i,
  output logic      hit_o,
  output spr_addr_t addr_o
);

  localparam logic [XY_W:0] SprWExt  = (XY_W + 1)'(SPR_W);
  localparam logic [XY_W:0] SprHExt  = (XY_W + 1)'(SPR_H);
  localparam spr_addr_t     SprWAddr = ADDR_W'(SPR_W);
  localparam spr_addr_t     SprWLast = ADDR_W'(SPR_W - 1);

  logic [XY_W:0] dx;
  logic [XY_W:0] dy;
  spr_addr_t     col;

  always_comb begin
    // One extra bit so a raster position left of / above the sprite shows up as
    // a set MSB instead of wrapping into the sprite box.
    dx    = {1'b0, draw_x_i} - {1'b0, sx_i};
    dy    = {1'b0, draw_y_i} - {1'b0, sy_i};
    hit_o = !dx[XY_W] && (dx < SprWExt) && !dy[XY_W] && (dy < SprHExt);
    col   = flip_i ? (SprWLast - spr_addr_t'(dx)) : spr_addr_t'(dx);
    // dy < SPR_H on a hit, so the row offset fits the address width.
    addr_o = spr_addr_t'(dy) * SprWAddr + col;
  end

endmodule

// File: rtl/sprite_fetch_unit.sv
// Sprite fetch stage sitting in front of the 60x60 sprite ROM.
// Generates the ROM read address from the raster position and the frame-latched
// sprite position, then realigns the returned palette index with the raster.
// Ports:
//   Clk, Reset_n        : clock, asynchronous active-low reset
//   pix_ce              : pixel clock-enable for the address stage
//   frame_start         : latches sprite_x / sprite_y / flip_h
//   DrawX, DrawY        : raster position
//   sprite_x, sprite_y  : sprite top-left corner
//   flip_h              : mirror sprite horizontally
//   rom_addr            : registered ROM read address
//   rom_data            : ROM read data, one Clk after rom_addr
//   pix_valid, pix_index: opaque-pixel flag and palette index, 2 Clk after sampling
module sprite_fetch_unit
  import sprite_pkg::*;
(
  input  logic      Clk,
  input  logic      Reset_n,
  input  logic      pix_ce,
  input  logic      frame_start,
  input  coord_t    DrawX,
  input  coord_t    DrawY,
  input  coord_t    sprite_x,
  input  coord_t    sprite_y,
  input  logic      flip_h,
  output spr_addr_t rom_addr,
  input  pal_idx_t  rom_data,
  output logic      pix_valid,
  output pal_idx_t  pix_index
);

  coord_t    sx_q, sx_d;
  coord_t    sy_q, sy_d;
  logic      flip_q, flip_d;
  spr_addr_t rom_addr_q, rom_addr_d;
  logic      hit_d1_q, hit_d1_d;
  logic      hit_d2_q, hit_d2_d;
  logic      pix_valid_q, pix_valid_d;
  pal_idx_t  pix_index_q, pix_index_d;

  logic      hit;
  spr_addr_t hit_addr;

  // Uses the currently latched values, so a frame_start coinciding with pix_ce
  // still samples against the previous frame's position.
  sprite_hit_calc u_hit_calc (
    .draw_x_i (DrawX),
    .draw_y_i (DrawY),
    .sx_i     (sx_q),
    .sy_i     (sy_q),
    .flip_i   (flip_q),
    .hit_o    (hit),
    .addr_o   (hit_addr)
  );

  always_comb begin
    sx_d        = sx_q;
    sy_d        = sy_q;
    flip_d      = flip_q;
    rom_addr_d  = rom_addr_q;
    hit_d1_d    = hit_d1_q;
    pix_valid_d = 1'b0;
    pix_index_d = '0;

    if (frame_start) begin
      sx_d   = sprite_x;
      sy_d   = sprite_y;
      flip_d = flip_h;
    end

    if (pix_ce) begin
      hit_d1_d = hit;
      // Hold the address on a miss to avoid needless ROM toggling.
      if (hit) begin
        rom_addr_d = hit_addr;
      end
    end

    // Ungated so the flag tracks the ROM's fixed one-Clk latency even when
    // pix_ce is held high continuously.
    hit_d2_d = hit_d1_q;

    if (hit_d2_q && (rom_data != TRANSPARENT)) begin
      pix_valid_d = 1'b1;
      pix_index_d = rom_data;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sx_q        <= '0;
      sy_q        <= '0;
      flip_q      <= 1'b0;
      rom_addr_q  <= '0;
      hit_d1_q    <= 1'b0;
      hit_d2_q    <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_index_q <= '0;
    end else begin
      sx_q        <= sx_d;
      sy_q        <= sy_d;
      flip_q      <= flip_d;
      rom_addr_q  <= rom_addr_d;
      hit_d1_q    <= hit_d1_d;
      hit_d2_q    <= hit_d2_d;
      pix_valid_q <= pix_valid_d;
      pix_index_q <= pix_index_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pix_valid = pix_valid_q;
  assign pix_index = pix_index_q;

endmodule

// File: tb/tb_sprite_fetch_unit.sv
// Directed self-checking bench for sprite_fetch_unit; rom_data is driven by the
// bench in place of the ROM, one Clk after the address is issued.
module tb_sprite_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic        frame_start = 1'b0;
  logic [9:0]  DrawX = '0;
  logic [9:0]  DrawY = '0;
  logic [9:0]  sprite_x = '0;
  logic [9:0]  sprite_y = '0;
  logic        flip_h = 1'b0;
  logic [11:0] rom_addr;
  logic [4:0]  rom_data = '0;
  logic        pix_valid;
  logic [4:0]  pix_index;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  sprite_fetch_unit dut (
    .Clk         (Clk),
    .Reset_n     (Reset_n),
    .pix_ce      (pix_ce),
    .frame_start (frame_start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .sprite_x    (sprite_x),
    .sprite_y    (sprite_y),
    .flip_h      (flip_h),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic latch(input logic [9:0] x, input logic [9:0] y, input logic f);
    sprite_x    = x;
    sprite_y    = y;
    flip_h      = f;
    frame_start = 1'b1;
    @(posedge Clk);
    #1;
    frame_start = 1'b0;
  endtask

  task automatic sample(input logic [9:0] x, input logic [9:0] y);
    DrawX  = x;
    DrawY  = y;
    pix_ce = 1'b1;
    @(posedge Clk);
    #1;
    pix_ce = 1'b0;
  endtask

  // Sample one raster position, check the address, feed ROM data and check
  // the aligned output two Clk later.
  task automatic pixel(input string tag, input logic [9:0] x, input logic [9:0] y,
                       input logic [4:0] d, input logic [11:0] ea, input logic ev,
                       input logic [4:0] ei);
    sample(x, y);
    chk({tag, ".addr"}, 32'(rom_addr), 32'(ea));
    rom_data = d;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk({tag, ".valid"}, 32'(pix_valid), 32'(ev));
    chk({tag, ".index"}, 32'(pix_index), 32'(ei));
  endtask

  initial begin
    #12;
    chk("rst.addr", 32'(rom_addr), 32'd0);
    chk("rst.valid", 32'(pix_valid), 32'd0);
    chk("rst.index", 32'(pix_index), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;

    latch(10'd100, 10'd50, 1'b0);
    pixel("origin", 10'd100, 10'd50, 5'd7, 12'd0, 1'b1, 5'd7);
    pixel("corner", 10'd159, 10'd109, 5'd9, 12'd3599, 1'b1, 5'd9);
    pixel("right_miss", 10'd160, 10'd109, 5'd9, 12'd3599, 1'b0, 5'd0);
    pixel("left_miss", 10'd99, 10'd50, 5'd9, 12'd3599, 1'b0, 5'd0);
    pixel("above_miss", 10'd120, 10'd49, 5'd9, 12'd3599, 1'b0, 5'd0);
    pixel("below_miss", 10'd120, 10'd110, 5'd9, 12'd3599, 1'b0, 5'd0);
    pixel("transparent", 10'd101, 10'd50, 5'd0, 12'd1, 1'b0, 5'd0);
    pixel("mid", 10'd110, 10'd52, 5'd31, 12'd130, 1'b1, 5'd31);

    latch(10'd100, 10'd50, 1'b1);
    pixel("flip_left", 10'd100, 10'd51, 5'd2, 12'd119, 1'b1, 5'd2);
    pixel("flip_right", 10'd159, 10'd51, 5'd3, 12'd60, 1'b1, 5'd3);

    latch(10'd100, 10'd50, 1'b0);
    // New position presented but not latched.
    sprite_x = 10'd300;
    pixel("no_latch", 10'd100, 10'd50, 5'd3, 12'd0, 1'b1, 5'd3);

    // frame_start coincides with a sampled pixel: old position applies.
    frame_start = 1'b1;
    pixel("coincide_old", 10'd101, 10'd50, 5'd4, 12'd1, 1'b1, 5'd4);
    frame_start = 1'b0;
    pixel("coincide_new", 10'd300, 10'd52, 5'd5, 12'd120, 1'b1, 5'd5);

    // pix_ce held high for three consecutive edges: hit, miss, hit.
    DrawX  = 10'd300;
    DrawY  = 10'd50;
    pix_ce = 1'b1;
    @(posedge Clk);
    #1;
    chk("cont.addr_a", 32'(rom_addr), 32'd0);
    rom_data = 5'd4;
    DrawX    = 10'd250;
    @(posedge Clk);
    #1;
    chk("cont.addr_b", 32'(rom_addr), 32'd0);
    DrawX = 10'd301;
    @(posedge Clk);
    #1;
    pix_ce = 1'b0;
    chk("cont.addr_c", 32'(rom_addr), 32'd1);
    chk("cont.valid_a", 32'(pix_valid), 32'd1);
    chk("cont.index_a", 32'(pix_index), 32'd4);
    rom_data = 5'd6;
    @(posedge Clk);
    #1;
    chk("cont.valid_b", 32'(pix_valid), 32'd0);
    @(posedge Clk);
    #1;
    chk("cont.valid_c", 32'(pix_valid), 32'd1);
    chk("cont.index_c", 32'(pix_index), 32'd6);

    // Asynchronous reset with a visible pixel and another hit in flight.
    pixel("pre_rst", 10'd300, 10'd51, 5'd11, 12'd60, 1'b1, 5'd11);
    sample(10'd301, 10'd51);
    chk("inflight.addr", 32'(rom_addr), 32'd61);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async.valid", 32'(pix_valid), 32'd0);
    chk("async.index", 32'(pix_index), 32'd0);
    chk("async.addr", 32'(rom_addr), 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("post_rst.valid", 32'(pix_valid), 32'd0);
    chk("post_rst.index", 32'(pix_index), 32'd0);
    pixel("post_rst_origin", 10'd0, 10'd0, 5'd5, 12'd0, 1'b1, 5'd5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
